// File: rtl/out_mem_reader.sv
// out_mem_reader
//   Drains the output SRAM (16 x 64-bit) after the MAC array has written its
//   T x M result matrix. One read is issued per occupied word. Each word is
//   unpacked into four 16-bit lanes, MSB lane first, and the lanes go out as a
//   row-major valid/ready element stream. Columns beyond M are never streamed.
//
//   Optional feature (macro OUT_MEM_READER_ZERO_CHECK_EN):
//     When the macro is defined, padding lanes of every word read are checked.
//     Any nonzero padding lane sets the sticky ERR flag. ERR is cleared by RST
//     or by the next accepted START. When the macro is undefined, ERR is tied
//     low and no compare logic is built.
//
//   Ports
//     CLK, RST            rising-edge clock, asynchronous active-high reset
//     START               begin a drain (accepted in IDLE only)
//     MNT                 M = [11:8], N = [7:4] (unused), T = [3:0]
//     EN_O, ADDR_O        SRAM read enable and address
//     RDATA_O             SRAM read data, valid the cycle after EN_O
//     DOUT, DOUT_VALID,
//     DOUT_READY,
//     DOUT_LAST           element stream; LAST marks element T*M
//     BUSY, DONE          BUSY from accepted START until DONE; DONE is a 1-cycle pulse
//     ERR                 sticky nonzero-padding flag
module out_mem_reader #(
    parameter int AW = 4,
    parameter int DW = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [11:0]     MNT,
    output logic            EN_O,
    output logic [AW-1:0]   ADDR_O,
    input  logic [DW-1:0]   RDATA_O,
    output logic [DW/4-1:0] DOUT,
    output logic            DOUT_VALID,
    input  logic            DOUT_READY,
    output logic            DOUT_LAST,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR
);

    localparam int EW = DW / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      m_q, t_q;
    logic [3:0]      m_in, t_in;
    logic [2:0]      row_q;
    logic            word_q;
    logic [1:0]      lane_q;
    logic [DW-1:0]   data_q;
    logic [2:0]      lane_cnt;
    logic            lane_last, word_last, row_last;
    logic            accept, hs;
    logic            unused_n;

    // N is not needed for draining; keep it visibly consumed.
    assign unused_n = ^MNT[7:4];

    // Dimensions above 8 are clamped to the 8x8 array size.
    assign m_in   = (MNT[11:8] > 4'd8) ? 4'd8 : MNT[11:8];
    assign t_in   = (MNT[3:0]  > 4'd8) ? 4'd8 : MNT[3:0];
    assign accept = (state_q == S_IDLE) && START;
    assign hs     = DOUT_VALID && DOUT_READY;

    // Word 0 carries columns 0..3, word 1 carries columns 4..M-1.
    assign lane_cnt  = word_q ? 3'(m_q - 4'd4) : ((m_q > 4'd4) ? 3'd4 : m_q[2:0]);
    assign lane_last = ({1'b0, lane_q} == (lane_cnt - 3'd1));
    assign word_last = word_q || (m_q <= 4'd4);
    assign row_last  = ({1'b0, row_q} == (t_q - 4'd1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = ((m_in == 4'd0) || (t_in == 4'd0)) ? S_FIN : S_RD;
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: state_d = S_SEND;
            S_SEND: begin
                if (hs && lane_last) state_d = (word_last && row_last) ? S_FIN : S_RD;
            end
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q    <= '0;
            t_q    <= '0;
            row_q  <= '0;
            word_q <= 1'b0;
            lane_q <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                m_q    <= m_in;
                t_q    <= t_in;
                row_q  <= '0;
                word_q <= 1'b0;
                lane_q <= '0;
            end
            if (state_q == S_WAIT) begin
                data_q <= RDATA_O;
                lane_q <= '0;
            end
            if ((state_q == S_SEND) && hs) begin
                if (!lane_last) begin
                    lane_q <= lane_q + 2'd1;
                end else if (!word_last) begin
                    word_q <= 1'b1;
                end else begin
                    word_q <= 1'b0;
                    row_q  <= row_q + 3'd1;
                end
            end
        end
    end

    assign EN_O       = (state_q == S_RD);
    assign ADDR_O     = AW'({row_q, word_q});
    assign DOUT_VALID = (state_q == S_SEND);
    assign DOUT_LAST  = (state_q == S_SEND) && lane_last && word_last && row_last;
    assign BUSY       = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_SEND);
    assign DONE       = (state_q == S_FIN);

    always_comb begin
        case (lane_q)
            2'd0:    DOUT = data_q[DW-1      -: EW];
            2'd1:    DOUT = data_q[DW-1-EW   -: EW];
            2'd2:    DOUT = data_q[DW-1-2*EW -: EW];
            default: DOUT = data_q[EW-1:0];
        endcase
    end

`ifdef OUT_MEM_READER_ZERO_CHECK_EN
    logic pad_nz;
    logic err_q;

    // Lanes at or beyond the valid lane count of the word being captured.
    always_comb begin
        pad_nz = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) >= lane_cnt) && (RDATA_O[DW-1-EW*i -: EW] != '0)) pad_nz = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                err_q <= 1'b0;
        else if (accept)                        err_q <= 1'b0;
        else if ((state_q == S_WAIT) && pad_nz) err_q <= 1'b1;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_out_mem_reader.sv
module tb_out_mem_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [11:0] MNT;
    logic        EN_O;
    logic [3:0]  ADDR_O;
    logic [63:0] RDATA_O;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;
    logic        DOUT_LAST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    out_mem_reader #(.AW(4), .DW(64)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
        .EN_O(EN_O), .ADDR_O(ADDR_O), .RDATA_O(RDATA_O),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
        .DOUT_LAST(DOUT_LAST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [16];
    int          exp_addr[$];
    logic [15:0] exp_el[$];
    logic [15:0] seen[$];
    int          en_count;
    bit          chk_on = 1'b0;
    bit          stall_q = 1'b0;
    logic [15:0] held;
    logic        held_last;

    // Synchronous-read SRAM: data appears the cycle after EN_O, garbage otherwise.
    always @(posedge CLK) RDATA_O <= EN_O ? mem[ADDR_O] : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: element (r,c) lives in word 2r + c/4, lane c%4 (lane 0 = top 16 bits).
    task automatic build_model(input logic [11:0] mnt, output int words, output bit err_exp);
        int m, t, nw;
        logic [15:0] e;
        m = int'(mnt[11:8]);
        t = int'(mnt[3:0]);
        if (m > 8) m = 8;
        if (t > 8) t = 8;
        exp_addr.delete();
        exp_el.delete();
        words = 0;
        err_exp = 1'b0;
        if (m == 0) t = 0;
        nw = (m + 3) / 4;
        for (int r = 0; r < t; r++) begin
            for (int w = 0; w < nw; w++) begin
                exp_addr.push_back(2 * r + w);
                words++;
            end
            for (int c = 0; c < 4 * nw; c++) begin
                e = 16'(mem[2 * r + c / 4] >> (16 * (3 - c % 4)));
                if (c < m) exp_el.push_back(e);
`ifdef OUT_MEM_READER_ZERO_CHECK_EN
                else if (e != 16'h0) err_exp = 1'b1;
`endif
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk_on && !RST) begin
            if (EN_O) begin
                en_count++;
                chk("en_while_valid", DOUT_VALID, 1'b0);
                if (exp_addr.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL extra_read: got addr 0x%0h, want no read", ADDR_O);
                end else begin
                    chk("addr", ADDR_O, 64'(exp_addr.pop_front()));
                end
            end
            if (stall_q) begin
                chk("hold_valid", DOUT_VALID, 1'b1);
                chk("hold_dout", DOUT, held);
                chk("hold_last", DOUT_LAST, held_last);
            end
            if (DOUT_VALID && DOUT_READY) begin
                seen.push_back(DOUT);
                if (exp_el.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL extra_elem: got 0x%0h, want no element", DOUT);
                end else begin
                    chk("dout", DOUT, exp_el.pop_front());
                    chk("last", DOUT_LAST, exp_el.size() == 0);
                end
            end
            stall_q   = DOUT_VALID && !DOUT_READY;
            held      = DOUT;
            held_last = DOUT_LAST;
        end
    end

    // One drain. rnd: random READY, MNT scrambled and START pulsed mid-drain.
    // fin_start: START raised during the FIN cycle, which must be ignored.
    task automatic run(input logic [11:0] mnt, input bit rnd, input int lit_cycles,
                       input bit fin_start, input string tag);
        int words, cyc, exp_cycles;
        bit err_exp, done_seen;
        build_model(mnt, words, err_exp);
        exp_cycles = words * 2 + exp_el.size() + 1;
        seen.delete();
        en_count = 0;
        stall_q = 1'b0;
        chk_on = 1'b1;
        @(posedge CLK); #1;
        MNT = mnt;
        START = 1'b1;
        DOUT_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        if (rnd) MNT = 12'hFFF;
        cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 400) begin
            if (cyc > 0) begin
                @(posedge CLK); #1;
            end
            if (rnd) DOUT_READY = 1'($urandom_range(0, 1));
            START = (rnd && cyc == 20) || (fin_start && cyc == exp_cycles - 1);
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_busy_first"}, BUSY, words > 0);
                chk({tag, "_en_first"}, EN_O, words > 0);
            end
            if (DONE) done_seen = 1'b1;
        end
        chk({tag, "_done_seen"}, done_seen, 1'b1);
        chk({tag, "_busy_at_done"}, BUSY, 1'b0);
        if (!rnd) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        if (lit_cycles > 0) chk({tag, "_cycles_lit"}, 64'(cyc), 64'(lit_cycles));
        chk({tag, "_err"}, ERR, err_exp);
        chk({tag, "_elems_left"}, 64'(exp_el.size()), 64'd0);
        chk({tag, "_reads_left"}, 64'(exp_addr.size()), 64'd0);
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        chk({tag, "_idle_done"}, DONE, 1'b0);
        chk({tag, "_idle_busy"}, BUSY, 1'b0);
        chk({tag, "_idle_en"}, EN_O, 1'b0);
        chk({tag, "_err_sticky"}, ERR, err_exp);
    endtask

    initial begin
        for (int a = 0; a < 16; a++)
            mem[a] = {8'(a), 8'h00, 8'(a), 8'h01, 8'(a), 8'h02, 8'(a), 8'h03};

        // Reset with garbage on the inputs.
        RST = 1'b1;
        START = 1'b1;
        MNT = 12'h888;
        DOUT_READY = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_en", EN_O, 1'b0);
            chk("rst_valid", DOUT_VALID, 1'b0);
            chk("rst_busy", BUSY, 1'b0);
            chk("rst_done", DONE, 1'b0);
            chk("rst_err", ERR, 1'b0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        START = 1'b0;

        run(12'h777, 1'b0, 78, 1'b0, "m7t7");
        chk("m7t7_reads", 64'(en_count), 64'd14);
        chk("m7t7_count", 64'(seen.size()), 64'd49);
        if (seen.size() == 49) begin
            chk("m7t7_e6", seen[6], 16'h0102);
            chk("m7t7_e7", seen[7], 16'h0200);
            chk("m7t7_e48", seen[48], 16'h0D02);
        end

        run(12'h302, 1'b0, 11, 1'b1, "m3t2");
        chk("m3t2_reads", 64'(en_count), 64'd2);
        chk("m3t2_count", 64'(seen.size()), 64'd6);
        if (seen.size() == 6) begin
            chk("m3t2_e0", seen[0], 16'h0000);
            chk("m3t2_e2", seen[2], 16'h0002);
            chk("m3t2_e3", seen[3], 16'h0200);
            chk("m3t2_e5", seen[5], 16'h0202);
        end

        run(12'h000, 1'b0, 1, 1'b0, "zero");
        chk("zero_reads", 64'(en_count), 64'd0);
        chk("zero_count", 64'(seen.size()), 64'd0);

        run(12'h888, 1'b0, 97, 1'b0, "m8t8");
        chk("m8t8_reads", 64'(en_count), 64'd16);

        // Asynchronous reset while a read is being issued.
        chk_on = 1'b0;
        @(posedge CLK); #1;
        MNT = 12'h888;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (7) @(negedge CLK);
        chk("mid_en_before", EN_O, 1'b1);
        chk("mid_addr_before", ADDR_O, 4'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_en", EN_O, 1'b0);
        chk("mid_rst_valid", DOUT_VALID, 1'b0);
        chk("mid_rst_busy", BUSY, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Nonzero padding in word 0 lane 3 with M=3.
        mem[0] = {16'h0000, 16'h0001, 16'h0002, 16'h0001};
        run(12'h301, 1'b0, 6, 1'b0, "zchk");
        chk("zchk_count", 64'(seen.size()), 64'd3);
`ifdef OUT_MEM_READER_ZERO_CHECK_EN
        chk("zchk_err_lit", ERR, 1'b1);
`else
        chk("zchk_err_lit", ERR, 1'b0);
`endif
        mem[0] = {16'h0000, 16'h0001, 16'h0002, 16'h0003};

        run(12'h888, 1'b1, 0, 1'b0, "m8t8_rnd");
        chk("m8t8_rnd_count", 64'(seen.size()), 64'd64);
        chk("m8t8_rnd_err_clr", ERR, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
